// File: rtl/hwag_angle_interp.sv
// Crank angle interpolator. It splits each tooth interval into 2^TSH ticks, paced by a
// Bresenham accumulator, and snaps the angle to the tooth boundary on every sensor edge.
//
// state | meaning
// IDLE  | waiting for a sync rise; tracking registers cleared
// RUN   | emitting angle ticks within the current tooth interval
// STALL | tick budget for the interval spent, waiting for the next edge
// LOST  | no edge within one period of stalling; frozen until sync drops
module hwag_angle_interp #(
    parameter int PW  = 24,
    parameter int TSH = 6,
    localparam int AW = 8 + TSH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sync,
    input  logic          tooth_edge,
    input  logic          gap_next,
    input  logic [PW-1:0] period,
    input  logic [7:0]    teeth_total,
    input  logic [2:0]    missing,
    output logic [AW-1:0] angle,
    output logic [7:0]    tooth_idx,
    output logic          angle_tick,
    output logic          angle_valid,
    output logic          gap_int,
    output logic          sync_err,
    output logic          lost
);
    localparam int SW = TSH + 4;
    localparam logic [PW:0]   TOOTH_TICKS = {{(PW-TSH){1'b0}}, 1'b1, {TSH{1'b0}}};
    localparam logic [SW-1:0] ONE_TOOTH   = {3'b000, 1'b1, {TSH{1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, STALL, LOST} state_t;

    state_t        state, state_nx;
    logic          sync_prev;
    logic [PW-1:0] acc, acc_nx, stall_cnt, stall_nx, stall_inc, stall_lim;
    logic [PW:0]   acc_sum;
    logic [SW-1:0] sub, sub_nx, sub_inc, budget_m1;
    logic [3:0]    gap_mult;
    logic [AW-1:0] angle_nx;
    logic [7:0]    idx_nx, snap_idx;
    logic [8:0]    step, idx_sum, idx_wrap;
    logic          gap_nx, tick_nx, err_nx, lost_nx, small_period, tick_hit;

    assign angle_valid = (state == RUN) || (state == STALL);

    always_comb begin
        gap_mult     = {1'b0, missing} + 4'd1;
        budget_m1    = (gap_int ? {gap_mult, {TSH{1'b0}}} : ONE_TOOTH) - SW'(1);
        step         = gap_int ? {5'd0, gap_mult} : 9'd1;
        idx_sum      = {1'b0, tooth_idx} + step;
        idx_wrap     = (idx_sum >= {1'b0, teeth_total}) ? 9'd0 : idx_sum;
        snap_idx     = gap_int ? 8'd0 : idx_wrap[7:0];
        acc_sum      = {1'b0, acc} + TOOTH_TICKS;
        small_period = ({1'b0, period} <= TOOTH_TICKS);
        tick_hit     = small_period || (acc_sum >= {1'b0, period});
        stall_inc    = stall_cnt + PW'(1);
        stall_lim    = (period == '0) ? PW'(1) : period;
        sub_inc      = sub + SW'(1);

        state_nx = state;
        angle_nx = angle;
        idx_nx   = tooth_idx;
        acc_nx   = acc;
        sub_nx   = sub;
        stall_nx = stall_cnt;
        gap_nx   = gap_int;
        tick_nx  = 1'b0;
        err_nx   = 1'b0;
        lost_nx  = 1'b0;

        if (!sync) begin
            state_nx = IDLE;
            angle_nx = '0;
            idx_nx   = '0;
            acc_nx   = '0;
            sub_nx   = '0;
            stall_nx = '0;
            gap_nx   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // sync rising marks the edge that closed the gap: angle 0
                    if (!sync_prev) begin
                        state_nx = RUN;
                        angle_nx = '0;
                        idx_nx   = '0;
                        acc_nx   = '0;
                        sub_nx   = '0;
                        stall_nx = '0;
                        gap_nx   = 1'b0;
                    end
                end
                RUN, STALL: begin
                    if (tooth_edge) begin
                        state_nx = RUN;
                        idx_nx   = snap_idx;
                        angle_nx = {snap_idx, {TSH{1'b0}}};
                        acc_nx   = '0;
                        sub_nx   = '0;
                        stall_nx = '0;
                        gap_nx   = gap_next;
                        err_nx   = gap_int && (idx_wrap != 9'd0);
                    end else if (state == RUN) begin
                        if (small_period) begin
                            acc_nx = '0;
                        end else if (tick_hit) begin
                            acc_nx = acc_sum[PW-1:0] - period;
                        end else begin
                            acc_nx = acc_sum[PW-1:0];
                        end
                        if (tick_hit) begin
                            tick_nx  = 1'b1;
                            angle_nx = angle + AW'(1);
                            sub_nx   = sub_inc;
                            if (sub_inc == budget_m1) begin
                                state_nx = STALL;
                            end
                        end
                    end else begin
                        stall_nx = stall_inc;
                        if (stall_inc >= stall_lim) begin
                            state_nx = LOST;
                            lost_nx  = 1'b1;
                        end
                    end
                end
                LOST: begin
                    state_nx = LOST;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            // treat sync as already high so re-entry needs a fresh rise
            sync_prev  <= 1'b1;
            angle      <= '0;
            tooth_idx  <= '0;
            acc        <= '0;
            sub        <= '0;
            stall_cnt  <= '0;
            gap_int    <= 1'b0;
            angle_tick <= 1'b0;
            sync_err   <= 1'b0;
            lost       <= 1'b0;
        end else begin
            state      <= state_nx;
            sync_prev  <= sync;
            angle      <= angle_nx;
            tooth_idx  <= idx_nx;
            acc        <= acc_nx;
            sub        <= sub_nx;
            stall_cnt  <= stall_nx;
            gap_int    <= gap_nx;
            angle_tick <= tick_nx;
            sync_err   <= err_nx;
            lost       <= lost_nx;
        end
    end
endmodule

// File: tb/tb_hwag_angle_interp.sv
// Scoreboard bench for hwag_angle_interp: expected tick angles are queued per interval
// and popped whenever the DUT raises angle_tick.
module tb_hwag_angle_interp;
    localparam int PW  = 24;
    localparam int TSH = 6;
    localparam int AW  = 8 + TSH;

    logic          clk = 1'b0;
    logic          rst, sync, tooth_edge, gap_next;
    logic [PW-1:0] period;
    logic [7:0]    teeth_total;
    logic [2:0]    missing;
    logic [AW-1:0] angle;
    logic [7:0]    tooth_idx;
    logic          angle_tick, angle_valid, gap_int, sync_err, lost;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];
    int cur_idx = 0;
    bit cur_gap = 1'b0;
    int k;

    always #5 clk = ~clk;

    hwag_angle_interp #(.PW(PW), .TSH(TSH)) dut (
        .clk(clk), .rst(rst), .sync(sync), .tooth_edge(tooth_edge), .gap_next(gap_next),
        .period(period), .teeth_total(teeth_total), .missing(missing),
        .angle(angle), .tooth_idx(tooth_idx), .angle_tick(angle_tick),
        .angle_valid(angle_valid), .gap_int(gap_int), .sync_err(sync_err), .lost(lost)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (angle_tick) begin
            if (exp_q.size() == 0) chk("tick_unexpected", int'(angle), -1);
            else chk("tick_angle", int'(angle), exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_rise();
        sync = 1'b1;
        step();
        chk("rise_valid", int'(angle_valid), 1);
        chk("rise_angle", int'(angle), 0);
        cur_idx = 0;
        cur_gap = 1'b0;
    endtask

    // One tooth interval of len clocks ending in an edge; ticks derive from len and period.
    task automatic interval(input int len, input int per, input bit gnext,
                            input int exp_idx, input bit exp_err);
        int n, cap, base;
        period = per;
        base = cur_idx << TSH;
        cap  = (cur_gap ? (1 + int'(missing)) : 1) * (1 << TSH) - 1;
        n    = (per <= (1 << TSH)) ? len - 1 : ((len - 1) * (1 << TSH)) / per;
        if (n > cap) n = cap;
        for (int i = 1; i <= n; i++) exp_q.push_back(base + i);
        repeat (len - 1) step();
        tooth_edge = 1'b1;
        gap_next   = gnext;
        step();
        tooth_edge = 1'b0;
        gap_next   = 1'b0;
        chk("pending_ticks", exp_q.size(), 0);
        chk("snap_angle", int'(angle), exp_idx << TSH);
        chk("snap_idx", int'(tooth_idx), exp_idx);
        chk("snap_no_tick", int'(angle_tick), 0);
        chk("sync_err", int'(sync_err), int'(exp_err));
        chk("gap_int", int'(gap_int), int'(gnext));
        chk("snap_valid", int'(angle_valid), 1);
        exp_q.delete();
        cur_idx = exp_idx;
        cur_gap = gnext;
    endtask

    initial begin
        rst = 1'b0; sync = 1'b0; tooth_edge = 1'b0; gap_next = 1'b0;
        period = 640; teeth_total = 60; missing = 2;
        repeat (3) step();
        chk("rst_angle", int'(angle), 0);
        chk("rst_idx", int'(tooth_idx), 0);
        chk("rst_valid", int'(angle_valid), 0);
        chk("rst_tick", int'(angle_tick), 0);
        chk("rst_lost", int'(lost), 0);
        rst = 1'b1;
        step();

        // reset mid-RUN, then sync held high must not re-enter
        sync_rise();
        exp_q.push_back(1);
        exp_q.push_back(2);
        repeat (25) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("midrst_angle", int'(angle), 0);
        chk("midrst_idx", int'(tooth_idx), 0);
        chk("midrst_valid", int'(angle_valid), 0);
        chk("midrst_pending", exp_q.size(), 0);
        repeat (20) step();
        chk("midrst_no_reentry", int'(angle_valid), 0);
        sync = 1'b0;
        step();

        // full 60-2 revolution: nominal, acceleration, tiny period, gap close
        sync_rise();
        interval(640, 640, 1'b0, 1, 1'b0);
        interval(500, 640, 1'b0, 2, 1'b0);
        interval(40, 32, 1'b0, 3, 1'b0);
        for (int t = 3; t <= 56; t++) interval(128, 128, (t == 56), t + 1, 1'b0);
        interval(1920, 640, 1'b0, 0, 1'b0);

        // gap declared one tooth early: closing edge lands on 59, forced to 0 with sync_err
        for (int t = 0; t <= 55; t++) interval(128, 128, (t == 55), t + 1, 1'b0);
        interval(384, 128, 1'b0, 0, 1'b1);

        // deceleration: no edge, budget spent, stall times out
        period = 640;
        for (int i = 1; i <= 63; i++) exp_q.push_back(i);
        step();
        chk("err_pulse_clear", int'(sync_err), 0);
        k = 1;
        while (!lost && k < 3000) begin
            step();
            k++;
        end
        chk("lost_cycle", k, 1270);
        chk("lost_valid", int'(angle_valid), 0);
        chk("lost_angle", int'(angle), 63);
        chk("lost_pending", exp_q.size(), 0);
        step();
        chk("lost_pulse_clear", int'(lost), 0);
        tooth_edge = 1'b1;
        step();
        tooth_edge = 1'b0;
        step();
        chk("lost_frozen_angle", int'(angle), 63);
        chk("lost_frozen_idx", int'(tooth_idx), 0);
        chk("lost_still_invalid", int'(angle_valid), 0);
        sync = 1'b0;
        step();
        chk("drop_angle", int'(angle), 0);
        chk("drop_valid", int'(angle_valid), 0);

        // sync drop on the same clock as an edge
        sync_rise();
        period = 640;
        exp_q.push_back(1);
        repeat (14) step();
        tooth_edge = 1'b1;
        sync = 1'b0;
        step();
        tooth_edge = 1'b0;
        chk("dropedge_valid", int'(angle_valid), 0);
        chk("dropedge_angle", int'(angle), 0);
        chk("dropedge_idx", int'(tooth_idx), 0);
        chk("dropedge_tick", int'(angle_tick), 0);
        chk("dropedge_err", int'(sync_err), 0);
        chk("dropedge_pending", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
